pwm_multi: RTL
==============

# pwm_multi

Multi-channel PWM generator that replaces the single-channel 8-bit PWM at the audio output stage. One shared counter drives `CHANNELS` compare channels, each with its own duty value. Duty, mode and prescale updates are double-buffered and take effect only at a period boundary, so changes are glitch-free. The block supports edge-aligned and center-aligned modes, sits after the signal mixer, and drives the output pins.

## Interface

Parameters:
- `WIDTH`, 8, counter/duty width; `MAX = 2**WIDTH-1`
- `CHANNELS`, 4, number of PWM outputs
- `DIV_W`, 8, prescaler divide-field width

Ports:
- `clk`  in  1  clock; one clock domain.
- `rst`  in  1  synchronous, active-high reset.
- `en`  in  1  run enable
- `mode`  in  `pwm_mode_t`  `PWM_EDGE` or `PWM_CENTER`; latched at boundary
- `div`  in  `DIV_W`  counter advances every `div+1` clocks; latched at boundary
- `duty_in`  in  `CHANNELS*WIDTH`  packed duties; channel i is `[i*WIDTH +: WIDTH]`
- `duty_valid`  in  1  duty update offered
- `duty_ready`  out  1  shadow free; accept when `duty_valid && duty_ready`
- `pwm_out`  out  `CHANNELS`  registered PWM outputs
- `period_start`  out  1  one-clock pulse marking a new period

## Operation

- **Prescaler:** `pre_cnt` counts 0..`div_act`. `tick` is high when `pre_cnt == div_act`, and `pre_cnt` returns to 0 on that cycle. With `div_act = 0`, `tick` is high every cycle.
- **Counter:** `cnt` (`WIDTH` bits) and `dir` (up/down) change only on `tick`.
  - Edge mode: `cnt` runs 0,1,…,MAX, then wraps to 0. Period is `2**WIDTH` ticks.
  - Center mode: `cnt` runs 0..MAX up, then MAX..0 down, so each endpoint appears twice. Period is `2**(WIDTH+1)` ticks.
- **Boundary:** a tick at which the next count starts a new up phase.
  - Edge mode: `cnt == MAX`.
  - Center mode: `cnt == 0 && dir == DOWN`.
  - The first cycle with `en` high after `en` was low is also a boundary; no tick is required.
- **At a boundary:**
  - If `pending` is set, `duty_act <= shadow` and `pending` clears.
  - `mode_act <= mode` and `div_act <= div`.
  - `cnt` goes to 0, `dir` goes to UP, and `pre_cnt` goes to 0.
- **Update handshake:**
  - `duty_ready = !pending && !rst`.
  - On accept, `shadow <= duty_in` and `pending <= 1`.
  - At most one update is accepted per period.
  - An accept in the same cycle as a boundary does not commit at that boundary; it commits at the next one.
- **Compare:** `pwm_out[i]` is high when `en && cnt < duty_act[i]`.
  - Duty 0 gives the output fully off.
  - Duty D gives D high ticks per period in edge mode and 2D in center mode.
  - Duty MAX gives MAX of `2**WIDTH` ticks high in edge mode; there is no 100% duty.
- **`en` low:**
  - `cnt`, `dir` and `pre_cnt` are held at 0 / UP / 0.
  - `pwm_out` and `period_start` are 0.
  - The handshake stays live, so the shadow can be loaded while idle.
- **Reset values:**
  - `cnt`, `pre_cnt`, `duty_act`, `shadow`, `pending`, `div_act`: 0.
  - `dir`: UP. `mode_act`: `PWM_EDGE`.
  - `pwm_out`, `period_start`, `duty_ready`: 0 while `rst` is high.
- **Reset mid-period:** all state returns to reset values on the next edge, and any pending update is dropped.

## Timing

- `pwm_out` is registered: `pwm_out(t+1)` is a function of `cnt(t)` and `duty_act(t)`, giving one clock of latency.
- `period_start` is registered: it is high for exactly one clock, on the cycle after a boundary.
- A new duty affects `pwm_out` one clock after the first post-boundary cycle.
- `duty_ready` drops the cycle after an accept. It rises the cycle after the commit boundary.

## Structure

- Package `pwm_pkg` holds:
  - `typedef enum logic {PWM_EDGE, PWM_CENTER} pwm_mode_t`
  - `typedef enum logic {DIR_UP, DIR_DOWN} pwm_dir_t`
- Sub-module `pwm_counter` contains the prescaler, `cnt`/`dir` sequencing and boundary detection.
  - Outputs: `cnt`, `tick`, `boundary`.
  - The top level holds the shadow/active registers, the handshake and the per-channel compare.

## Test plan

Bench parameters: `WIDTH=4`, `CHANNELS=2`, `div=0` unless stated.

- **Reset:** hold `rst` 3 cycles with `en=1`, `duty_valid=1` → `pwm_out=0`, `period_start=0`, `duty_ready=0`. After release, `duty_ready=1`.
- **Edge duty:** load duties {3,0}, `en=1`, `PWM_EDGE` → ch0 high exactly 3 of every 16 clocks, ch1 constantly 0, `period_start` every 16 clocks.
- **Center mode:** `PWM_CENTER`, duty 5 → ch0 high 10 of every 32 clocks, symmetric about the period boundary; `cnt` shows 15 twice and 0 twice.
- **Double-buffered update:** with duty 8 active, accept duty 2 mid-period → output unchanged until the boundary; `duty_ready=0` until then. A second `duty_valid` is not accepted, and the next period is 2 high.
- **Prescaler:** `div=3`, edge, duty 4 → period 64 clocks, 16 high. A `div` change to 0 mid-period takes effect only at the next `period_start`.
- **Enable/reset mid-period:** drop `en` at `cnt=7` → outputs 0 the next clock. On re-raising `en`, `period_start` fires after 1 clock and `cnt` restarts at 0. Asserting `rst` mid-period clears `pending`.

Source files
------------

// File: rtl/pwm_pkg.sv
// pwm_pkg: shared types for the multi-channel PWM generator
package pwm_pkg;
    typedef enum logic {PWM_EDGE, PWM_CENTER} pwm_mode_t;
    typedef enum logic {DIR_UP, DIR_DOWN} pwm_dir_t;
endpackage

// File: rtl/pwm_counter.sv
// pwm_counter: prescaler, shared up/up-down counter and period boundary detection
module pwm_counter
    import pwm_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  pwm_mode_t        mode,
    input  logic [DIV_W-1:0] div,
    output logic [WIDTH-1:0] cnt,
    output logic             tick,
    output logic             boundary
);
    localparam logic [WIDTH-1:0] MAX = '1;

    logic [DIV_W-1:0] pre_cnt;
    pwm_dir_t         dir;
    logic             en_d;
    logic             wrap;

    // a boundary is the last tick of a period, or the first enabled cycle after idle
    always_comb begin
        tick     = en && pre_cnt == div;
        wrap     = mode == PWM_EDGE ? cnt == MAX : cnt == '0 && dir == DIR_DOWN;
        boundary = en && (!en_d || (tick && wrap));
    end

    // remembers last cycle's enable to spot the idle-to-run transition
    always_ff @(posedge clk) begin
        en_d <= !rst && en;
    end

    // center mode holds MAX for one extra tick while turning around, giving 2**(WIDTH+1) ticks
    always_ff @(posedge clk) begin
        if (rst || !en || boundary) begin
            cnt     <= '0;
            dir     <= DIR_UP;
            pre_cnt <= '0;
        end else if (tick) begin
            pre_cnt <= '0;
            if (mode == PWM_CENTER && dir == DIR_DOWN)
                cnt <= cnt - 1'b1;
            else if (mode == PWM_CENTER && cnt == MAX)
                dir <= DIR_DOWN;
            else
                cnt <= cnt + 1'b1;
        end else begin
            pre_cnt <= pre_cnt + 1'b1;
        end
    end
endmodule

// File: rtl/pwm_multi.sv
// pwm_multi: multi-channel PWM with double-buffered duty, mode and prescale updates
module pwm_multi
    import pwm_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int DIV_W    = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  pwm_mode_t                 mode,
    input  logic [DIV_W-1:0]          div,
    input  logic [CHANNELS*WIDTH-1:0] duty_in,
    input  logic                      duty_valid,
    output logic                      duty_ready,
    output logic [CHANNELS-1:0]       pwm_out,
    output logic                      period_start
);
    logic [CHANNELS*WIDTH-1:0] shadow;
    logic [CHANNELS*WIDTH-1:0] duty_act;
    logic                      pending;
    pwm_mode_t                 mode_act;
    logic [DIV_W-1:0]          div_act;
    logic [WIDTH-1:0]          cnt;
    logic                      tick;
    logic                      boundary;
    logic                      accept;

    pwm_counter #(.WIDTH(WIDTH), .DIV_W(DIV_W)) u_cnt (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .mode     (mode_act),
        .div      (div_act),
        .cnt      (cnt),
        .tick     (tick),
        .boundary (boundary)
    );

    // the prescaler never ticks while the block is idle
    assert property (@(posedge clk) tick |-> en);

    // shadow is free only when nothing awaits commit
    always_comb begin
        duty_ready = !pending && !rst;
        accept     = duty_valid && duty_ready;
    end

    // commit happens before accept can refill the shadow, so a same-cycle accept waits a full period
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow       <= '0;
            duty_act     <= '0;
            pending      <= 1'b0;
            mode_act     <= PWM_EDGE;
            div_act      <= '0;
            pwm_out      <= '0;
            period_start <= 1'b0;
        end else begin
            if (boundary) begin
                mode_act <= mode;
                div_act  <= div;
            end
            if (boundary && pending)
                duty_act <= shadow;
            if (accept)
                shadow <= duty_in;
            pending      <= accept || (pending && !boundary);
            period_start <= boundary;
            for (int i = 0; i < CHANNELS; i++)
                pwm_out[i] <= en && cnt < duty_act[i*WIDTH +: WIDTH];
        end
    end
endmodule
